// File: rtl/ram_loader.sv
// ram_loader: front-end for a 16x4 board RAM. Debounces the write and mode
// buttons. In LOAD it writes the switch value at an auto-incrementing address.
// In SCAN it steps the address at a fixed slow rate so contents show on q.
module ram_loader #(
  parameter int unsigned DEB_CYCLES  = 500000,
  parameter int unsigned SCAN_PERIOD = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_wr,
  input  logic       btn_mode,
  input  logic [3:0] sw_data,
  output logic [3:0] ram_addr,
  output logic [3:0] ram_data,
  output logic       ram_wr,
  output logic       mode,
  output logic       wrap
);

  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned SW = $clog2(SCAN_PERIOD);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_PERIOD - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_WRITE,
    S_SCAN
  } state_t;

  // Bit 0 is the write button, bit 1 the mode button.
  logic [1:0]    btn;
  logic [1:0]    sync0;
  logic [1:0]    sync1;
  logic [1:0]    level;
  logic [1:0]    level_d;
  logic [1:0]    press;
  logic [DW-1:0] deb_cnt [2];

  logic wr_ev;
  logic mode_ev;

  state_t        state;
  state_t        state_n;
  logic [SW-1:0] scan_cnt;
  logic [SW-1:0] scan_n;
  logic [3:0]    addr_n;
  logic [3:0]    data_n;
  logic          wr_n;
  logic          wrap_n;
  logic          mode_n;

  assign btn     = {btn_mode, btn_wr};
  assign wr_ev   = press[0];
  assign mode_ev = press[1];

  // Synchronize, debounce and edge-detect both buttons.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0      <= '0;
      sync1      <= '0;
      level      <= '0;
      level_d    <= '0;
      press      <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      sync0   <= btn;
      sync1   <= sync0;
      level_d <= level;
      press   <= level & ~level_d;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync1[i] == level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          // This edge is the DEB_CYCLES-th consecutive differing sample.
          level[i]   <= sync1[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // State, scan counter and all RAM-facing outputs are registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_LOAD;
      scan_cnt <= '0;
      ram_addr <= '0;
      ram_data <= '0;
      ram_wr   <= 1'b0;
      mode     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      state    <= state_n;
      scan_cnt <= scan_n;
      ram_addr <= addr_n;
      ram_data <= data_n;
      ram_wr   <= wr_n;
      mode     <= mode_n;
      wrap     <= wrap_n;
    end
  end

  // Next-state and next-output logic; a mode event always takes priority.
  always_comb begin
    state_n = state;
    scan_n  = scan_cnt;
    addr_n  = ram_addr;
    data_n  = ram_data;
    wr_n    = 1'b0;
    wrap_n  = 1'b0;
    unique case (state)
      S_LOAD: begin
        if (mode_ev) begin
          addr_n  = '0;
          scan_n  = '0;
          state_n = S_SCAN;
        end else if (wr_ev) begin
          data_n  = sw_data;
          wr_n    = 1'b1;
          state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        if (mode_ev) begin
          addr_n  = '0;
          scan_n  = '0;
          state_n = S_SCAN;
        end else begin
          addr_n  = ram_addr + 4'd1;
          wrap_n  = (ram_addr == 4'hF);
          state_n = S_LOAD;
        end
      end
      S_SCAN: begin
        if (mode_ev) begin
          addr_n  = '0;
          state_n = S_LOAD;
        end else if (scan_cnt == SCAN_LAST) begin
          scan_n = '0;
          addr_n = ram_addr + 4'd1;
          wrap_n = (ram_addr == 4'hF);
        end else begin
          scan_n = scan_cnt + SW'(1);
        end
      end
      default: state_n = S_LOAD;
    endcase
    mode_n = (state_n == S_SCAN);
  end

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader with DEB_CYCLES=4, SCAN_PERIOD=8.
module tb_ram_loader;

  localparam int unsigned DEB = 4;
  localparam int unsigned PER = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_wr;
  logic       btn_mode;
  logic [3:0] sw_data;
  logic [3:0] ram_addr;
  logic [3:0] ram_data;
  logic       ram_wr;
  logic       mode;
  logic       wrap;

  always #5 clk = ~clk;

  ram_loader #(
    .DEB_CYCLES (DEB),
    .SCAN_PERIOD(PER)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_wr  (btn_wr),
    .btn_mode(btn_mode),
    .sw_data (sw_data),
    .ram_addr(ram_addr),
    .ram_data(ram_data),
    .ram_wr  (ram_wr),
    .mode    (mode),
    .wrap    (wrap)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // RAM model and pulse counters, sampled 1 time unit after each falling edge.
  int         wr_cnt = 0;
  int         wrap_cnt = 0;
  logic [3:0] last_addr = '0;
  logic [3:0] last_data = '0;
  logic [3:0] mem [16];

  always @(negedge clk) begin
    #1;
    if (ram_wr === 1'b1) begin
      wr_cnt++;
      last_addr = ram_addr;
      last_data = ram_data;
      mem[ram_addr] = ram_data;
    end
    if (wrap === 1'b1) begin
      wrap_cnt++;
      check("wrap_addr_zero", ram_addr, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean press of the write button; lat = falling edge index where ram_wr first seen.
  task automatic press_wr(input logic [3:0] v, output int lat);
    lat     = 0;
    sw_data = v;
    btn_wr  = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (ram_wr === 1'b1 && lat == 0) lat = k;
    end
    btn_wr = 1'b0;
    tick(10);
  endtask

  // Clean press of the mode button; lat = falling edge index where mode toggled.
  task automatic press_mode(output int lat);
    logic m0;
    m0       = mode;
    lat      = 0;
    btn_mode = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (mode !== m0 && lat == 0) lat = k;
    end
    btn_mode = 1'b0;
    tick(10);
  endtask

  typedef struct {
    logic [3:0] sw;
    logic [3:0] exp_addr;
    logic [3:0] exp_data;
    int         exp_wraps;
    logic [3:0] exp_next;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int lat;
    int wr0;
    int w0;

    tbl[0]  = '{4'h0, 4'h0, 4'h0, 0, 4'h1};
    tbl[1]  = '{4'h1, 4'h1, 4'h1, 0, 4'h2};
    tbl[2]  = '{4'h2, 4'h2, 4'h2, 0, 4'h3};
    tbl[3]  = '{4'h3, 4'h3, 4'h3, 0, 4'h4};
    tbl[4]  = '{4'h4, 4'h4, 4'h4, 0, 4'h5};
    tbl[5]  = '{4'h5, 4'h5, 4'h5, 0, 4'h6};
    tbl[6]  = '{4'h6, 4'h6, 4'h6, 0, 4'h7};
    tbl[7]  = '{4'h7, 4'h7, 4'h7, 0, 4'h8};
    tbl[8]  = '{4'h8, 4'h8, 4'h8, 0, 4'h9};
    tbl[9]  = '{4'h9, 4'h9, 4'h9, 0, 4'hA};
    tbl[10] = '{4'hA, 4'hA, 4'hA, 0, 4'hB};
    tbl[11] = '{4'hB, 4'hB, 4'hB, 0, 4'hC};
    tbl[12] = '{4'hC, 4'hC, 4'hC, 0, 4'hD};
    tbl[13] = '{4'hD, 4'hD, 4'hD, 0, 4'hE};
    tbl[14] = '{4'hE, 4'hE, 4'hE, 0, 4'hF};
    tbl[15] = '{4'hF, 4'hF, 4'hF, 1, 4'h0};

    // 1. Reset with both buttons held high.
    rst = 1'b1; btn_wr = 1'b1; btn_mode = 1'b1; sw_data = 4'h5;
    tick(2);
    check("rst_addr", ram_addr, 0);
    check("rst_data", ram_data, 0);
    check("rst_wr", ram_wr, 0);
    check("rst_mode", mode, 0);
    check("rst_wrap", wrap, 0);
    rst = 1'b0;
    tick(1);
    btn_wr = 1'b0; btn_mode = 1'b0;
    tick(20);
    check("rst_no_write", wr_cnt, 0);
    check("rst_still_load", mode, 0);

    // 2. Bounce rejection, then a held press.
    sw_data = 4'hA;
    for (int i = 0; i < 10; i++) begin
      btn_wr = (i % 2 == 0);
      tick(2);
    end
    check("bounce_no_write", wr_cnt, 0);
    btn_wr = 1'b1;
    tick(14);
    check("bounce_one_write", wr_cnt, 1);
    check("bounce_addr", last_addr, 0);
    check("bounce_data", last_data, 4'hA);
    check("bounce_addr_after", ram_addr, 1);
    check("bounce_no_wrap", wrap_cnt, 0);
    btn_wr = 1'b0;
    tick(10);
    check("release_no_write", wr_cnt, 1);

    // 3. Sixteen writes wrap the address.
    rst = 1'b1; tick(2); rst = 1'b0; tick(1);
    wr0 = wr_cnt; w0 = wrap_cnt;
    for (int i = 0; i < 16; i++) begin
      press_wr(tbl[i].sw, lat);
      check("wr_latency", lat, 8);
      check("wr_addr", last_addr, tbl[i].exp_addr);
      check("wr_data", last_data, tbl[i].exp_data);
      check("wr_count", wr_cnt - wr0, i + 1);
      check("wr_wraps", wrap_cnt - w0, tbl[i].exp_wraps);
      check("wr_next_addr", ram_addr, tbl[i].exp_next);
    end
    for (int a = 0; a < 16; a++) check("ram_readback", mem[a], tbl[a].exp_data);

    // 4. SCAN mode stepping, wrap, and ignored write presses.
    wr0 = wr_cnt; w0 = wrap_cnt;
    sw_data = 4'h0;
    btn_mode = 1'b1;
    for (int n = 1; n <= 140; n++) begin
      @(negedge clk);
      if (n == 7) check("scan_entry_not_early", mode, 0);
      if (n >= 8) begin
        check("scan_addr", ram_addr, ((n - 8) / 8) % 16);
        check("scan_wrap", wrap, (n == 136) ? 1 : 0);
      end
      if (n == 8) check("scan_mode", mode, 1);
      if (n == 14) btn_mode = 1'b0;
      if (n == 40) btn_wr = 1'b1;
      if (n == 60) btn_wr = 1'b0;
    end
    check("scan_no_write", wr_cnt - wr0, 0);
    check("scan_wrap_count", wrap_cnt - w0, 1);
    check("scan_mode_held", mode, 1);
    press_mode(lat);
    check("exit_latency", lat, 8);
    check("exit_mode", mode, 0);
    check("exit_addr", ram_addr, 0);

    // 5a. Coinciding write and mode events: mode wins.
    wr0 = wr_cnt;
    btn_wr = 1'b1; btn_mode = 1'b1;
    tick(14);
    check("both_mode", mode, 1);
    check("both_no_write", wr_cnt - wr0, 0);
    btn_wr = 1'b0; btn_mode = 1'b0;
    tick(10);
    press_mode(lat);
    check("both_back_load", mode, 0);

    // 5b. Mode event on the WRITE edge suppresses the increment.
    press_wr(4'h3, lat);
    check("pre_addr", ram_addr, 1);
    wr0 = wr_cnt; w0 = wrap_cnt;
    sw_data = 4'h7;
    btn_wr = 1'b1;
    tick(1);
    btn_mode = 1'b1;
    tick(7);
    check("wm_wr_high", ram_wr, 1);
    check("wm_addr_during", ram_addr, 1);
    check("wm_data_during", ram_data, 4'h7);
    tick(1);
    check("wm_wr_low", ram_wr, 0);
    check("wm_mode", mode, 1);
    check("wm_addr_zero", ram_addr, 0);
    check("wm_no_wrap", wrap, 0);
    tick(5);
    btn_wr = 1'b0; btn_mode = 1'b0;
    tick(10);
    check("wm_wrap_count", wrap_cnt - w0, 0);
    check("wm_write_count", wr_cnt - wr0, 1);
    press_mode(lat);
    check("wm_back_load", mode, 0);

    // 6a. Reset during the WRITE cycle.
    btn_wr = 1'b1;
    tick(8);
    check("rw_wr_high", ram_wr, 1);
    rst = 1'b1; btn_wr = 1'b0;
    tick(1);
    rst = 1'b0;
    check("rw_wr", ram_wr, 0);
    check("rw_addr", ram_addr, 0);
    check("rw_mode", mode, 0);
    check("rw_data", ram_data, 0);
    tick(12);

    // 6b. Reset mid-SCAN at address 5.
    btn_mode = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (n == 14) btn_mode = 1'b0;
    end
    check("rs_addr_before", ram_addr, 5);
    check("rs_mode_before", mode, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rs_addr", ram_addr, 0);
    check("rs_mode", mode, 0);
    check("rs_wr", ram_wr, 0);
    check("rs_wrap", wrap, 0);
    tick(10);
    check("rs_stays_load", mode, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
# ram_loader

Front-end controller that sits directly upstream of the 16x4 board RAM and drives its `addr`, `data` and `wr` pins from board switches and pushbuttons. In LOAD mode, each debounced press of the write button stores the 4-bit switch value at an auto-incrementing address. In SCAN mode, the block steps the RAM address at a slow, fixed rate so stored contents read back on `q`/LEDs. All outputs are registered and are intended to connect straight to the RAM ports.

## Interface
Parameters:
- `DEB_CYCLES`, default 500000: consecutive stable synchronized samples required to accept a button level change; legal range ≥ 2.
- `SCAN_PERIOD`, default 25000000: clk cycles per address step in SCAN mode; legal range ≥ 2.

Ports:
- `clk`, in, 1: system clock. All logic is on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `btn_wr`, in, 1: raw asynchronous write pushbutton, active-high, bouncy.
- `btn_mode`, in, 1: raw asynchronous mode pushbutton, active-high, bouncy.
- `sw_data`, in, 4: switch value to be written.
- `ram_addr`, out, 4: RAM address.
- `ram_data`, out, 4: RAM write data.
- `ram_wr`, out, 1: RAM write enable, one-cycle pulse.
- `mode`, out, 1: 0 = LOAD, 1 = SCAN.
- `wrap`, out, 1: one-cycle pulse when `ram_addr` advances from 15 to 0.

## Operation
- **Input path:** each button has its own path.
  - Two-flop synchronizer.
  - Debounce counter: counts edges where the synchronized value differs from the accepted level. The counter clears on any edge where they match.
  - When the count reaches `DEB_CYCLES`, the accepted level takes the synchronized value and the counter clears.
  - A 0→1 change of the accepted level produces a one-cycle press event. Releases produce no event.
- **States:** LOAD, WRITE, SCAN.
- **LOAD:**
  - wr event → latch `sw_data` into `ram_data`, assert `ram_wr`, go to WRITE.
  - mode event → `ram_addr`=0, scan counter=0, go to SCAN.
  - If wr and mode events occur on the same edge, mode wins and the write is dropped.
- **WRITE** (exactly one cycle, `ram_wr`=1):
  - On the next edge, deassert `ram_wr` and set `ram_addr` = `ram_addr`+1 mod 16. When the address goes 15→0, pulse `wrap`.
  - If a mode event arrives on that edge, go to SCAN with `ram_addr`=0; the increment and `wrap` are suppressed. Otherwise return to LOAD.
- **SCAN:**
  - `ram_wr` is held 0 and wr events are ignored.
  - The scan counter counts 0..`SCAN_PERIOD`-1. On the terminal count, the counter clears, `ram_addr` increments mod 16, and `wrap` pulses on 15→0.
  - mode event → `ram_addr`=0, go to LOAD. The scan counter is not reloaded.
- `ram_data` changes only when a write is launched, and holds its value otherwise, including in SCAN.
- **Widths:**
  - Address arithmetic is 4-bit and wraps naturally.
  - The debounce counter is sized by $clog2(`DEB_CYCLES`+1).
  - The scan counter is sized by $clog2(`SCAN_PERIOD`).

## Timing
- **Reset:** all outputs are 0 (`ram_addr`, `ram_data`, `ram_wr`, `mode`, `wrap`). State is LOAD; synchronizers, accepted levels and all counters are 0.
- **Reset mid-operation:** `rst` asserted during WRITE or SCAN forces reset values on that edge. `ram_wr` is low in the following cycle.
- **Button latency:** raw input rises between edges 0 and 1 and stays clean.
  - The synchronized value is high after edge 2.
  - The accepted level rises at edge 2+`DEB_CYCLES`.
  - The event is registered at edge 3+`DEB_CYCLES`.
  - `ram_wr` is high for exactly the cycle after edge 4+`DEB_CYCLES`.
- **RAM handshake:** the RAM samples `ram_addr`/`ram_data` while `ram_wr`=1. Address and data are stable for the whole `ram_wr` cycle. The address changes only on the edge that ends the pulse.
- **Repeat rate:** at most one write per button press. Holding the button does not repeat.
- **`mode`:** changes on the same edge as the state transition.
- **SCAN step timing:** the first address step occurs `SCAN_PERIOD` edges after entry to SCAN. `wrap` is high in the same cycle that `ram_addr`=0 first appears.

## Test plan
Test parameters: `DEB_CYCLES`=4, `SCAN_PERIOD`=8.

1. **Reset:** assert `rst` for 2 cycles with buttons high → all outputs 0 and `mode`=0. No `ram_wr` until a release followed by a fresh debounced press.
2. **Bounce rejection:** toggle `btn_wr` every 2 cycles for 20 cycles, then hold high → exactly one `ram_wr` pulse with `ram_addr`=0 and `ram_data`=`sw_data` (0xA). `ram_addr` becomes 1 afterwards.
3. **Wrap on writes:** 16 clean presses with `sw_data`=press index → writes to addresses 0..15 with data 0..15. `wrap` pulses once, on the 16th press; `ram_addr` returns to 0. A RAM model reads back 0..15.
4. **SCAN mode:** press `btn_mode` → `mode`=1 and `ram_addr`=0. `ram_addr` increments every 8 cycles; `wrap` pulses after 128 cycles. A `btn_wr` press in SCAN produces no `ram_wr`.
5. **Simultaneous events:** drive both buttons identically so their events coincide in LOAD → go to SCAN, no `ram_wr`. Separately, a mode event on the WRITE edge → SCAN with `ram_addr`=0 and no `wrap`.
6. **Reset mid-operation:** assert `rst` in the WRITE cycle and mid-SCAN (`ram_addr`=5) → next cycle `ram_wr`=0, `ram_addr`=0, `mode`=0.
